lsu_wb_master: RTL and testbench
================================

Name: lsu_wb_master

Overview:
- MEM-stage load/store unit that turns one pipeline memory request into one Wishbone B4 classic single-beat bus cycle.
- Performs byte-lane steering for stores and aligns plus sign/zero-extends load data.
- Produces `mem_done_o`, which the hazard unit combines with `mem_req_i` to stall EX/MEM and MEM/WB while an access is outstanding.
- Sits between the EX/MEM pipeline register and the data bus.

Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles in BUS before the watchdog aborts. Used only with `LSU_WB_TIMEOUT_EN`. Minimum 1.

Ports:
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  asynchronous active-low reset
- `mem_req_i`  in  1  MEM-stage instruction is a load/store; held high while stalled
- `mem_we_i`  in  1  1 = store, 0 = load
- `mem_addr_i`  in  32  byte address
- `mem_wdata_i`  in  32  store data, right-justified
- `mem_size_i`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `mem_unsigned_i`  in  1  zero-extend load (LBU/LHU)
- `mem_kill_i`  in  1  MEM instruction is flushed/trapped; suppresses launch
- `mem_done_o`  out  1  one-cycle completion pulse
- `mem_rdata_o`  out  32  aligned, extended load data; valid with `mem_done_o`
- `mem_fault_o`  out  1  access fault (`wb_err_i` or timeout); valid with done
- `mem_misaligned_o`  out  1  misaligned or reserved size; valid with done
- `wb_cyc_o`  out  1  bus cycle
- `wb_stb_o`  out  1  strobe
- `wb_we_o`  out  1  write enable
- `wb_adr_o`  out  32  word address, bits [1:0] = 0
- `wb_dat_o`  out  32  lane-replicated write data
- `wb_sel_o`  out  4  byte select
- `wb_dat_i`  in  32  read data
- `wb_ack_i`  in  1  slave acknowledge
- `wb_err_i`  in  1  slave error

Behaviour:
- Reset (async, `rst_ni` = 0):
  - state = IDLE.
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o` = 0.
  - `wb_adr_o`, `wb_dat_o`, `mem_rdata_o` = 0; `wb_sel_o` = 0.
  - `mem_done_o`, `mem_fault_o`, `mem_misaligned_o` = 0.
  - Reset asserted mid-transaction drops `cyc`/`stb` immediately; the transaction is abandoned.
- Misalignment:
  - half with `addr[0]` = 1 is misaligned.
  - word with `addr[1:0]` ≠ 0 is misaligned.
  - size 11 is always treated as misaligned.
- Lane steering:
  - `wb_sel_o`: byte = `4'b0001 << addr[1:0]`; half = `4'b0011 << addr[1:0]`; word = `4'hF`.
  - `wb_dat_o`: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load align: take `wb_dat_i >> (8*addr[1:0])`, keep the low byte or half, then sign-extend, or zero-extend if `mem_unsigned_i`. Word passes through.
- FSM, all outputs registered:
  - IDLE:
    - `mem_req_i && !mem_kill_i && !misaligned`: latch `adr`/`sel`/`dat`/`we`, `addr[1:0]`, size and unsigned; assert `cyc`/`stb` next cycle; go to BUS.
    - `mem_req_i && !mem_kill_i && misaligned`: go to DONE with `mem_misaligned_o` = 1 and no bus activity.
    - Kill, or no request: stay in IDLE.
  - BUS:
    - Hold all bus outputs stable.
    - On `wb_ack_i`: deassert `cyc`/`stb`, capture aligned `rdata` (loads only; stores leave `rdata` = 0), go to DONE.
    - On `wb_err_i`: deassert `cyc`/`stb`, set fault, go to DONE.
    - `ack` and `err` in the same cycle: `err` wins.
  - DONE:
    - `mem_done_o` = 1 for exactly this cycle.
    - Flags and `rdata` are valid.
    - Next state is IDLE, which clears done and the flags.
- Latency:
  - `req` sampled in cycle 0; `cyc`/`stb` high from cycle 1.
  - Ack in cycle k (k ≥ 1) gives `mem_done_o` in cycle k+1.
  - Misaligned request: done in cycle 1.
- Stall contract:
  - `mem_req_i` stays high until done. The pipeline advances on the done cycle's edge.
  - A back-to-back request is sampled in IDLE on the following cycle. No request is ever launched twice.
- Kill after launch:
  - the bus cycle completes (Wishbone cannot abort).
  - done still pulses.
  - The consumer discards the result.

Optional Feature:
- `LSU_WB_TIMEOUT_EN` defined:
  - An 8–16-bit counter clears on entry to BUS and increments each BUS cycle.
  - When it reaches `TIMEOUT_CYCLES` without `ack`/`err`: drop `cyc`/`stb`, go to DONE with `mem_fault_o` = 1.
  - An `ack` arriving in the same cycle as the timeout wins.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- `params_pkg` additions:
  - `mem_size_t` enum (`MEM_SIZE_BYTE`/`HALF`/`WORD`/`RSVD`).
  - `lsu_state_t` (`LSU_IDLE`, `LSU_BUS`, `LSU_DONE`).
- Sub-module `lsu_load_align`, purely combinational: inputs `wb_dat_i`, `addr[1:0]`, size, unsigned; output extended data.

Test Plan:
- Load word at 0x1000, slave acks 2 cycles after `stb`, data 0xDEADBEEF → `wb_sel_o` = F, `wb_adr_o` = 0x1000, `mem_done_o` high exactly one cycle, `rdata` = 0xDEADBEEF.
- LB at 0x2003 with bus data 0x80112233 → `sel` = 1000, `rdata` = 0xFFFFFF80. Same access as LBU → 0x00000080.
- SH 0xABCD1234 at 0x3002 → `sel` = 1100, `wb_dat_o` = 0x12341234, `we` = 1, done one cycle after ack.
- LW at 0x4001 → no `cyc`, done in cycle 1, `mem_misaligned_o` = 1. `mem_kill_i` with `req` in IDLE → no `cyc`, no done.
- `wb_err_i` and `wb_ack_i` together → `mem_fault_o` = 1. Back-to-back requests → exactly two bus cycles.
- With `LSU_WB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, slave silent → fault + done 5 cycles after `stb`. `rst_ni` low mid-BUS → `cyc` = 0 asynchronously.

Source files
------------

// File: rtl/lsu_wb_master_pkg.sv
// Shared types and lane-steering helpers for the lsu_wb_master load/store unit.
package lsu_wb_master_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'b00,
        MEM_SIZE_HALF = 2'b01,
        MEM_SIZE_WORD = 2'b10,
        MEM_SIZE_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUS  = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_t;

    // Reserved size is never legal, whatever the offset.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        case (size)
            MEM_SIZE_BYTE: return 1'b0;
            MEM_SIZE_HALF: return off[0];
            MEM_SIZE_WORD: return off != 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input mem_size_t size, input logic [1:0] off);
        case (size)
            MEM_SIZE_BYTE: return 4'b0001 << off;
            MEM_SIZE_HALF: return 4'b0011 << off;
            default:       return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lane_dat(input mem_size_t size, input logic [31:0] wdata);
        case (size)
            MEM_SIZE_BYTE: return {4{wdata[7:0]}};
            MEM_SIZE_HALF: return {2{wdata[15:0]}};
            default:       return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_wb_master_load_align.sv
// Load-data aligner: shifts the addressed lane down and sign/zero-extends it.
module lsu_load_align
    import lsu_wb_master_pkg::*;
(
    input  logic [31:0] wb_dat_i,
    input  logic [1:0]  addr,
    input  mem_size_t   size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = wb_dat_i >> {addr, 3'b000};
        case (size)
            MEM_SIZE_BYTE: data = {{24{~uns & shifted[7]}}, shifted[7:0]};
            MEM_SIZE_HALF: data = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default:       data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_wb_master.sv
// MEM-stage load/store unit issuing one Wishbone B4 classic single-beat cycle per request.
// Optional bus watchdog enabled by defining LSU_WB_TIMEOUT_EN.
module lsu_wb_master
    import lsu_wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic        mem_kill_i,
    output logic        mem_done_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_fault_o,
    output logic        mem_misaligned_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("lsu_wb_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    lsu_state_t  state_q, state_d;
    mem_size_t   req_size, size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic        launch, misaligned, bus_tmo, bus_end;
    logic [31:0] load_data;

    assign req_size   = mem_size_t'(mem_size_i);
    assign launch     = mem_req_i && !mem_kill_i;
    assign misaligned = is_misaligned(req_size, mem_addr_i[1:0]);

`ifdef LSU_WB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Held at zero outside BUS, so it restarts from zero on every entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                tmo_cnt_q <= '0;
        else if (state_q != LSU_BUS) tmo_cnt_q <= '0;
        else                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end

    assign bus_tmo = !wb_ack_i && !wb_err_i && (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
`else
    assign bus_tmo = 1'b0;
`endif

    assign bus_end = wb_ack_i || wb_err_i || bus_tmo;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= LSU_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no branch leaves state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (launch) state_d = misaligned ? LSU_DONE : LSU_BUS;
            LSU_BUS:  if (bus_end) state_d = LSU_DONE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    lsu_load_align u_align (
        .wb_dat_i (wb_dat_i),
        .addr     (off_q),
        .size     (size_q),
        .uns      (uns_q),
        .data     (load_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_cyc_o         <= 1'b0;
            wb_stb_o         <= 1'b0;
            wb_we_o          <= 1'b0;
            wb_adr_o         <= '0;
            wb_dat_o         <= '0;
            wb_sel_o         <= '0;
            mem_rdata_o      <= '0;
            mem_done_o       <= 1'b0;
            mem_fault_o      <= 1'b0;
            mem_misaligned_o <= 1'b0;
            off_q            <= '0;
            size_q           <= MEM_SIZE_BYTE;
            uns_q            <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults overridden later in the block make done/flags one-cycle pulses.
            mem_done_o       <= 1'b0;
            mem_fault_o      <= 1'b0;
            mem_misaligned_o <= 1'b0;
            case (state_q)
                LSU_IDLE: begin
                    if (launch) begin
                        mem_rdata_o <= '0;
                        if (misaligned) begin
                            mem_done_o       <= 1'b1;
                            mem_misaligned_o <= 1'b1;
                        end else begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= mem_we_i;
                            wb_adr_o <= {mem_addr_i[31:2], 2'b00};
                            wb_sel_o <= lane_sel(req_size, mem_addr_i[1:0]);
                            wb_dat_o <= lane_dat(req_size, mem_wdata_i);
                            off_q    <= mem_addr_i[1:0];
                            size_q   <= req_size;
                            uns_q    <= mem_unsigned_i;
                        end
                    end
                end
                LSU_BUS: begin
                    if (bus_end) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        mem_done_o  <= 1'b1;
                        mem_fault_o <= wb_err_i || bus_tmo;
                        // Error beats a simultaneous ack; stores never return data.
                        mem_rdata_o <= (wb_ack_i && !wb_err_i && !wb_we_o) ? load_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed self-checking bench for lsu_wb_master (default build; watchdog steps under LSU_WB_TIMEOUT_EN).
module tb_lsu_wb_master;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_req_i, mem_we_i, mem_unsigned_i, mem_kill_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [1:0]  mem_size_i;
    logic        mem_done_o, mem_fault_o, mem_misaligned_o;
    logic [31:0] mem_rdata_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_rises = 0;

    lsu_wb_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .mem_req_i        (mem_req_i),
        .mem_we_i         (mem_we_i),
        .mem_addr_i       (mem_addr_i),
        .mem_wdata_i      (mem_wdata_i),
        .mem_size_i       (mem_size_i),
        .mem_unsigned_i   (mem_unsigned_i),
        .mem_kill_i       (mem_kill_i),
        .mem_done_o       (mem_done_o),
        .mem_rdata_o      (mem_rdata_o),
        .mem_fault_o      (mem_fault_o),
        .mem_misaligned_o (mem_misaligned_o),
        .wb_cyc_o         (wb_cyc_o),
        .wb_stb_o         (wb_stb_o),
        .wb_we_o          (wb_we_o),
        .wb_adr_o         (wb_adr_o),
        .wb_dat_o         (wb_dat_o),
        .wb_sel_o         (wb_sel_o),
        .wb_dat_i         (wb_dat_i),
        .wb_ack_i         (wb_ack_i),
        .wb_err_i         (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge wb_cyc_o) cyc_rises++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
        mem_req_i      = 1'b1;
        mem_we_i       = we;
        mem_addr_i     = addr;
        mem_wdata_i    = wdata;
        mem_size_i     = size;
        mem_unsigned_i = uns;
    endtask

    task automatic release_req();
        mem_req_i = 1'b0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_unsigned_i = 1'b0; mem_kill_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; mem_size_i = 2'b00;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

        // Reset state
        #12;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_rdata", mem_rdata_o, 0);
        chk("rst_flags", {mem_done_o, mem_fault_o, mem_misaligned_o}, 0);
        rst_ni = 1'b1;
        tick();

        // LW 0x1000, ack two cycles after stb rises
        issue(1'b0, 32'h0000_1000, 32'h0, 2'b10, 1'b0);
        tick();
        chk("lw_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b110);
        chk("lw_sel", wb_sel_o, 4'hF);
        chk("lw_adr", wb_adr_o, 32'h0000_1000);
        chk("lw_nodone", mem_done_o, 0);
        tick();
        chk("lw_wait1", {wb_cyc_o, mem_done_o}, 2'b10);
        tick();
        chk("lw_wait2", {wb_cyc_o, mem_done_o}, 2'b10);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick();
        chk("lw_done", mem_done_o, 1);
        chk("lw_rdata", mem_rdata_o, 32'hDEAD_BEEF);
        chk("lw_cyc_drop", {wb_cyc_o, wb_stb_o}, 2'b00);
        chk("lw_noflags", {mem_fault_o, mem_misaligned_o}, 2'b00);
        release_req();
        tick();
        chk("lw_done_pulse", mem_done_o, 0);
        tick();

        // LB / LBU at 0x2003, data 0x80112233
        issue(1'b0, 32'h0000_2003, 32'h0, 2'b00, 1'b0);
        tick();
        chk("lb_sel", wb_sel_o, 4'b1000);
        chk("lb_adr", wb_adr_o, 32'h0000_2000);
        wb_ack_i = 1'b1; wb_dat_i = 32'h8011_2233;
        tick();
        chk("lb_rdata", mem_rdata_o, 32'hFFFF_FF80);
        chk("lb_done", mem_done_o, 1);
        release_req();
        tick();
        issue(1'b0, 32'h0000_2003, 32'h0, 2'b00, 1'b1);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h8011_2233;
        tick();
        chk("lbu_rdata", mem_rdata_o, 32'h0000_0080);
        release_req();
        tick();

        // LH at 0x6002 (signed) and LHU at 0x6000
        issue(1'b0, 32'h0000_6002, 32'h0, 2'b01, 1'b0);
        tick();
        chk("lh_sel", wb_sel_o, 4'b1100);
        wb_ack_i = 1'b1; wb_dat_i = 32'h8001_7FFF;
        tick();
        chk("lh_rdata", mem_rdata_o, 32'hFFFF_8001);
        release_req();
        tick();
        issue(1'b0, 32'h0000_6000, 32'h0, 2'b01, 1'b1);
        tick();
        chk("lhu_sel", wb_sel_o, 4'b0011);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_ABCD;
        tick();
        chk("lhu_rdata", mem_rdata_o, 32'h0000_ABCD);
        release_req();
        tick();

        // SH 0xABCD1234 at 0x3002, ack one cycle late
        issue(1'b1, 32'h0000_3002, 32'hABCD_1234, 2'b01, 1'b0);
        tick();
        chk("sh_sel", wb_sel_o, 4'b1100);
        chk("sh_dat", wb_dat_o, 32'h1234_1234);
        chk("sh_we", wb_we_o, 1);
        chk("sh_adr", wb_adr_o, 32'h0000_3000);
        tick();
        chk("sh_hold", {wb_cyc_o, wb_sel_o, mem_done_o}, {1'b1, 4'b1100, 1'b0});
        wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        tick();
        chk("sh_done", mem_done_o, 1);
        chk("sh_rdata_zero", mem_rdata_o, 0);
        release_req();
        tick();

        // SB 0xA5 at 0x8001
        issue(1'b1, 32'h0000_8001, 32'h0000_00A5, 2'b00, 1'b0);
        tick();
        chk("sb_sel", wb_sel_o, 4'b0010);
        chk("sb_dat", wb_dat_o, 32'hA5A5_A5A5);
        wb_ack_i = 1'b1;
        tick();
        release_req();
        tick();

        // Misaligned LW at 0x4001: done in cycle 1, no bus cycle
        cyc_rises = 0;
        issue(1'b0, 32'h0000_4001, 32'h0, 2'b10, 1'b0);
        tick();
        chk("mis_done", mem_done_o, 1);
        chk("mis_flag", mem_misaligned_o, 1);
        chk("mis_nocyc", wb_cyc_o, 0);
        release_req();
        tick();
        chk("mis_clear", {mem_done_o, mem_misaligned_o}, 2'b00);

        // Reserved size is always misaligned
        issue(1'b0, 32'h0000_4000, 32'h0, 2'b11, 1'b0);
        tick();
        chk("rsvd_mis", {mem_done_o, mem_misaligned_o, wb_cyc_o}, 3'b110);
        release_req();
        tick();

        // Kill with request in IDLE: nothing happens
        issue(1'b0, 32'h0000_4100, 32'h0, 2'b10, 1'b0);
        mem_kill_i = 1'b1;
        tick();
        chk("kill_nocyc", {wb_cyc_o, mem_done_o}, 2'b00);
        tick();
        tick();
        chk("kill_still_idle", {wb_cyc_o, mem_done_o}, 2'b00);
        chk("kill_no_bus_rise", cyc_rises, 0);
        mem_kill_i = 1'b0;
        release_req();
        tick();

        // ack and err together: err wins
        issue(1'b0, 32'h0000_5000, 32'h0, 2'b10, 1'b0);
        tick();
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h1111_1111;
        tick();
        chk("err_done", mem_done_o, 1);
        chk("err_fault", mem_fault_o, 1);
        chk("err_rdata", mem_rdata_o, 0);
        release_req();
        tick();
        chk("err_clear", mem_fault_o, 0);

        // Back-to-back loads: exactly two bus cycles
        cyc_rises = 0;
        issue(1'b0, 32'h0000_7000, 32'h0, 2'b10, 1'b0);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0001;
        tick();
        chk("b2b_done1", mem_done_o, 1);
        wb_ack_i = 1'b0;
        issue(1'b0, 32'h0000_7004, 32'h0, 2'b10, 1'b0);
        tick();
        chk("b2b_gap", {wb_cyc_o, mem_done_o}, 2'b00);
        tick();
        chk("b2b_adr2", wb_adr_o, 32'h0000_7004);
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0002;
        tick();
        chk("b2b_rdata2", mem_rdata_o, 32'h0000_0002);
        release_req();
        tick();
        tick();
        chk("b2b_cycles", cyc_rises, 2);

`ifdef LSU_WB_TIMEOUT_EN
        // Silent slave with TIMEOUT_CYCLES = 4: fault + done 5 cycles after stb
        issue(1'b0, 32'h0000_9000, 32'h0, 2'b10, 1'b0);
        tick();
        chk("tmo_stb", wb_stb_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tmo_wait", {wb_cyc_o, mem_done_o}, 2'b10);
        end
        tick();
        chk("tmo_done", {mem_done_o, mem_fault_o, wb_cyc_o}, 3'b110);
        release_req();
        tick();
`endif

        // Reset asserted mid-BUS drops cyc/stb without waiting for a clock
        issue(1'b0, 32'h0000_A000, 32'h0, 2'b10, 1'b0);
        tick();
        chk("rstbus_cyc_before", wb_cyc_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rstbus_cyc_async", {wb_cyc_o, wb_stb_o}, 2'b00);
        chk("rstbus_sel", wb_sel_o, 0);
        release_req();
        #10;
        rst_ni = 1'b1;
        tick();
        tick();
        chk("rstbus_idle", {wb_cyc_o, mem_done_o}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
